// File: rtl/conv_pkg.sv
// Stage codes and shared derivations for the convolution pass controller
// and the weight cache that decodes the same stage bus.
package conv_pkg;

  localparam logic [2:0] STAGE_INIT    = 3'd0;
  localparam logic [2:0] STAGE_PRELOAD = 3'd1;
  localparam logic [2:0] STAGE_ROW_0   = 3'd2;
  localparam logic [2:0] STAGE_ROW_1   = 3'd3;
  localparam logic [2:0] STAGE_ROW_2   = 3'd4;
  localparam logic [2:0] STAGE_BIAS    = 3'd5;
  localparam logic [2:0] STAGE_LOAD    = 3'd6;
  localparam logic [2:0] STAGE_IDLE    = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT    = STAGE_INIT,
    ST_PRELOAD = STAGE_PRELOAD,
    ST_ROW_0   = STAGE_ROW_0,
    ST_ROW_1   = STAGE_ROW_1,
    ST_ROW_2   = STAGE_ROW_2,
    ST_BIAS    = STAGE_BIAS,
    ST_LOAD    = STAGE_LOAD,
    ST_IDLE    = STAGE_IDLE
  } stage_e;

  function automatic int out_rows(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_phase_timer.sv
// Loadable down-counter timing each controller stage; zero marks the stage's
// last cycle.
module conv_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/conv_stage_ctrl.sv
// Convolution pass sequencer: PRELOAD, then per output row ROW_0..ROW_2, BIAS,
// LOAD. Optional cycle counter enabled by CONV_STAGE_CTRL_PERF_EN.
module conv_stage_ctrl
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int IMAGE_SIZE     = 8,
  parameter int ARRAY_SIZE     = 6,
  parameter int PRELOAD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [2:0]  o_state,
  output logic        o_busy,
  output logic [2:0]  o_row_idx,
  output logic        o_row_valid,
  output logic        o_done
`ifdef CONV_STAGE_CTRL_PERF_EN
  ,output logic [15:0] o_cycle_cnt
`endif
);

  localparam int OUT_ROWS = out_rows(IMAGE_SIZE, KERNEL_SIZE);
  localparam int TMAX     = max_int(PRELOAD_CYCLES, KERNEL_SIZE);
  localparam int TW       = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam logic [2:0] LAST_ROW = 3'(OUT_ROWS - 1);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("conv_stage_ctrl: KERNEL_SIZE must be 3");
  end
  if (OUT_ROWS != ARRAY_SIZE) begin : g_bad_rows
    $error("conv_stage_ctrl: IMAGE_SIZE-KERNEL_SIZE+1 must equal ARRAY_SIZE");
  end
  if (PRELOAD_CYCLES < 1) begin : g_bad_preload
    $error("conv_stage_ctrl: PRELOAD_CYCLES must be >= 1");
  end

  stage_e        state_q, state_d;
  logic [2:0]    row_idx_q;
  logic          row_valid_q, done_q;
  logic          busy, start_accept, abort_busy;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

  assign busy         = (state_q != ST_INIT) && (state_q != ST_IDLE);
  assign start_accept = (state_q == ST_IDLE) && i_start && !i_abort;
  assign abort_busy   = busy && i_abort;

  conv_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (busy),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: if (start_accept) begin
        state_d  = ST_PRELOAD;
        tmr_load = 1'b1;
        tmr_val  = TW'(PRELOAD_CYCLES - 1);
      end
      ST_PRELOAD, ST_ROW_0, ST_ROW_1: if (tmr_zero) begin
        state_d  = (state_q == ST_PRELOAD) ? ST_ROW_0 :
                   (state_q == ST_ROW_0)   ? ST_ROW_1 : ST_ROW_2;
        tmr_load = 1'b1;
        tmr_val  = TW'(KERNEL_SIZE - 1);
      end
      ST_ROW_2: if (tmr_zero) state_d = ST_BIAS;
      ST_BIAS:  state_d = (row_idx_q == LAST_ROW) ? ST_IDLE : ST_LOAD;
      ST_LOAD: begin
        state_d  = ST_ROW_0;
        tmr_load = 1'b1;
        tmr_val  = TW'(KERNEL_SIZE - 1);
      end
      default: state_d = ST_INIT;
    endcase
    // Abort overrides any stage transition and clears the timer.
    if (abort_busy) begin
      state_d  = ST_IDLE;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_valid_q <= (state_q == ST_BIAS) && !i_abort;
      done_q      <= (state_q == ST_BIAS) && (row_idx_q == LAST_ROW) && !i_abort;
      if (start_accept || abort_busy) begin
        row_idx_q <= '0;
      end else if (state_q == ST_LOAD) begin
        row_idx_q <= row_idx_q + 3'd1;
      end
    end
  end

`ifdef CONV_STAGE_CTRL_PERF_EN
  logic [15:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (start_accept) begin
      cycle_cnt_q <= '0;
    end else if (busy && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 16'd1;
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
`endif

  assign o_state     = state_q;
  assign o_busy      = busy;
  assign o_row_idx   = row_idx_q;
  assign o_row_valid = row_valid_q;
  assign o_done      = done_q;

endmodule
